// File: rtl/mc_control_p.sv
// mc_control_p: multicycle RV32I control unit.
//   Sequences fetch, decode and execute, and waits on memory with an optional
//   timeout. Misaligned load/store can optionally trap. Illegal opcodes and
//   memory timeouts also trap, and the trap is sticky until reset.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   opcode/funct3/funct7 fields of the instruction register
//   br_en                comparator result
//   addr_lo              effective address bits [1:0] from the ALU
//   mem_resp             memory completion pulse
//   load_en              {pc,ir,regfile,mar,mdr,data_out} load strobes
//   *mux*_sel            datapath select lines
//   cmpop, aluop         comparator / ALU operation
//   mem_read/mem_write   memory requests, held until mem_resp
//   mem_byte_enable      write byte lanes
//   trap, trap_cause     sticky error flag and its cause
//   instret              retired-instruction counter
module mc_control_p #(
  parameter int unsigned TIMEOUT       = 64,
  parameter int unsigned CNT_W         = 32,
  parameter int unsigned MISALIGN_TRAP = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic             br_en,
  input  logic [1:0]       addr_lo,
  input  logic             mem_resp,
  output logic [5:0]       load_en,
  output logic             pcmux_sel,
  output logic             alumux1_sel,
  output logic [1:0]       alumux2_sel,
  output logic [1:0]       alumux3_sel,
  output logic [2:0]       regfilemux_sel,
  output logic             marmux_sel,
  output logic             cmpmux_sel,
  output logic [2:0]       cmpop,
  output logic [2:0]       aluop,
  output logic             mem_read,
  output logic             mem_write,
  output logic [3:0]       mem_byte_enable,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [4:0] {
    FETCH1, FETCH2, FETCH3, DECODE, IMM, REG, LUI, AUIPC, BR, JAL, JALR,
    CALC_ADDR, LD1, LD2, ST1, ST2, TRAP
  } state_t;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SRA  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b011;
  localparam logic [2:0] CMP_BLT  = 3'b100;
  localparam logic [2:0] CMP_BLTU = 3'b110;
  localparam logic [2:0] F3_ADD   = 3'b000;
  localparam logic [2:0] F3_SLT   = 3'b010;
  localparam logic [2:0] F3_SLTU  = 3'b011;
  localparam logic [2:0] F3_SR    = 3'b101;
  localparam logic [6:0] F7_ALT   = 7'b0100000;

  localparam int unsigned LD_PC   = 5;
  localparam int unsigned LD_IR   = 4;
  localparam int unsigned LD_RF   = 3;
  localparam int unsigned LD_MAR  = 2;
  localparam int unsigned LD_MDR  = 1;
  localparam int unsigned LD_DOUT = 0;

  localparam logic [1:0] CAUSE_ILLEGAL  = 2'd0;
  localparam logic [1:0] CAUSE_MISALIGN = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'd2;

  // Counter only needs to reach TIMEOUT-1.
  localparam int unsigned WAIT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned WAIT_MAX = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  state_t              state, next_state;
  logic [1:0]          next_cause;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [1:0]          addr_lo_q;
  logic [2:0]          funct3_q;
  logic                timeout_hit;
  logic                misaligned;
  logic                in_wait, next_in_wait;
  logic [3:0]          st_be;

  assign timeout_hit  = (TIMEOUT != 0) && (wait_cnt == WAIT_W'(WAIT_MAX));
  assign misaligned   = ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00)) ||
                        ((funct3[1:0] == 2'b01) && addr_lo[0]);
  assign in_wait      = (state == FETCH2) || (state == LD1) || (state == ST1);
  assign next_in_wait = (next_state == FETCH2) || (next_state == LD1) ||
                        (next_state == ST1);

  // Store lanes come from the values latched in CALC_ADDR, since the ALU
  // result no longer holds the address once the access is in flight.
  always_comb begin
    st_be = '1;
    case (funct3_q)
      3'b000:  st_be = 4'b0001 << addr_lo_q;
      3'b001:  st_be = 4'b0011 << addr_lo_q;
      default: st_be = '1;
    endcase
  end

  always_comb begin
    next_state      = state;
    next_cause      = CAUSE_ILLEGAL;
    load_en         = '0;
    pcmux_sel       = 1'b0;
    alumux1_sel     = 1'b0;
    alumux2_sel     = '0;
    alumux3_sel     = '0;
    regfilemux_sel  = '0;
    marmux_sel      = 1'b0;
    cmpmux_sel      = 1'b0;
    cmpop           = funct3;
    aluop           = funct3;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_byte_enable = '1;

    if (!rst_n) begin
      next_state = FETCH1;
    end else begin
      case (state)
        FETCH1: begin
          load_en[LD_MAR] = 1'b1;
          next_state      = FETCH2;
        end
        FETCH2: begin
          mem_read        = 1'b1;
          load_en[LD_MDR] = 1'b1;
          if (mem_resp) begin
            next_state = FETCH3;
          end else if (timeout_hit) begin
            next_state = TRAP;
            next_cause = CAUSE_TIMEOUT;
          end
        end
        FETCH3: begin
          load_en[LD_IR] = 1'b1;
          next_state     = DECODE;
        end
        DECODE: begin
          case (opcode)
            OP_LUI:   next_state = LUI;
            OP_AUIPC: next_state = AUIPC;
            OP_JAL:   next_state = JAL;
            OP_JALR:  next_state = JALR;
            OP_BR:    next_state = BR;
            OP_IMM:   next_state = IMM;
            OP_REG:   next_state = REG;
            OP_LOAD,
            OP_STORE: next_state = CALC_ADDR;
            default: begin
              next_state = TRAP;
              next_cause = CAUSE_ILLEGAL;
            end
          endcase
        end
        IMM: begin
          load_en[LD_RF] = 1'b1;
          load_en[LD_PC] = 1'b1;
          next_state     = FETCH1;
          case (funct3)
            F3_SLT: begin
              cmpop = CMP_BLT;  cmpmux_sel = 1'b1; regfilemux_sel = 3'd1;
            end
            F3_SLTU: begin
              cmpop = CMP_BLTU; cmpmux_sel = 1'b1; regfilemux_sel = 3'd1;
            end
            F3_SR:   if (funct7 == F7_ALT) aluop = ALU_SRA;
            default: ;
          endcase
        end
        REG: begin
          alumux3_sel    = 2'd1;
          load_en[LD_RF] = 1'b1;
          load_en[LD_PC] = 1'b1;
          next_state     = FETCH1;
          case (funct3)
            F3_SLT: begin
              cmpop = CMP_BLT;  regfilemux_sel = 3'd1;
            end
            F3_SLTU: begin
              cmpop = CMP_BLTU; regfilemux_sel = 3'd1;
            end
            F3_ADD:  if (funct7 == F7_ALT) aluop = ALU_SUB;
            F3_SR:   if (funct7 == F7_ALT) aluop = ALU_SRA;
            default: ;
          endcase
        end
        LUI: begin
          regfilemux_sel = 3'd2;
          load_en[LD_RF] = 1'b1;
          load_en[LD_PC] = 1'b1;
          next_state     = FETCH1;
        end
        AUIPC: begin
          alumux1_sel    = 1'b1;
          alumux2_sel    = 2'd1;
          aluop          = ALU_ADD;
          load_en[LD_RF] = 1'b1;
          load_en[LD_PC] = 1'b1;
          next_state     = FETCH1;
        end
        BR: begin
          pcmux_sel      = br_en;
          alumux1_sel    = 1'b1;
          alumux2_sel    = 2'd2;
          aluop          = ALU_ADD;
          load_en[LD_PC] = 1'b1;
          next_state     = FETCH1;
        end
        JAL, JALR: begin
          alumux1_sel    = (state == JAL);
          alumux3_sel    = (state == JAL) ? 2'd2 : 2'd0;
          aluop          = ALU_ADD;
          regfilemux_sel = 3'd4;
          pcmux_sel      = 1'b1;
          load_en[LD_RF] = 1'b1;
          load_en[LD_PC] = 1'b1;
          next_state     = FETCH1;
        end
        CALC_ADDR: begin
          aluop      = ALU_ADD;
          marmux_sel = 1'b1;
          if (opcode == OP_STORE) alumux2_sel = 2'd3;
          if ((MISALIGN_TRAP != 0) && misaligned) begin
            next_state = TRAP;
            next_cause = CAUSE_MISALIGN;
          end else begin
            load_en[LD_MAR] = 1'b1;
            if (opcode == OP_STORE) begin
              load_en[LD_DOUT] = 1'b1;
              next_state       = ST1;
            end else begin
              next_state = LD1;
            end
          end
        end
        LD1: begin
          mem_read        = 1'b1;
          load_en[LD_MDR] = 1'b1;
          if (mem_resp) begin
            next_state = LD2;
          end else if (timeout_hit) begin
            next_state = TRAP;
            next_cause = CAUSE_TIMEOUT;
          end
        end
        LD2: begin
          regfilemux_sel = 3'd3;
          load_en[LD_RF] = 1'b1;
          load_en[LD_PC] = 1'b1;
          next_state     = FETCH1;
        end
        ST1: begin
          mem_write       = 1'b1;
          mem_byte_enable = st_be;
          if (mem_resp) begin
            next_state = ST2;
          end else if (timeout_hit) begin
            next_state = TRAP;
            next_cause = CAUSE_TIMEOUT;
          end
        end
        ST2: begin
          mem_byte_enable = st_be;
          load_en[LD_PC]  = 1'b1;
          next_state      = FETCH1;
        end
        TRAP:    next_state = TRAP;
        default: next_state = FETCH1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= FETCH1;
      instret    <= '0;
      trap       <= 1'b0;
      trap_cause <= '0;
      wait_cnt   <= '0;
      addr_lo_q  <= '0;
      funct3_q   <= '0;
    end else begin
      state <= next_state;
      if (load_en[LD_PC]) instret <= instret + CNT_W'(1);
      // Cause is captured only on the transition into TRAP.
      if ((next_state == TRAP) && (state != TRAP)) begin
        trap       <= 1'b1;
        trap_cause <= next_cause;
      end
      if (state == CALC_ADDR) begin
        addr_lo_q <= addr_lo;
        funct3_q  <= funct3;
      end
      if (next_in_wait && (next_state != state)) begin
        wait_cnt <= '0;
      end else if (in_wait && !mem_resp) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mc_control_p.sv
module tb_mc_control_p;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       br_en;
  logic [1:0] addr_lo;
  logic       mem_resp;
  logic [5:0] load_en;
  logic       pcmux_sel, alumux1_sel, marmux_sel, cmpmux_sel;
  logic [1:0] alumux2_sel, alumux3_sel;
  logic [2:0] regfilemux_sel, cmpop, aluop;
  logic       mem_read, mem_write;
  logic [3:0] mem_byte_enable;
  logic       trap;
  logic [1:0] trap_cause;
  logic [3:0] instret;

  int checks = 0;
  int errors = 0;

  localparam logic [5:0] L_PC   = 6'b100000;
  localparam logic [5:0] L_IR   = 6'b010000;
  localparam logic [5:0] L_RF   = 6'b001000;
  localparam logic [5:0] L_MAR  = 6'b000100;
  localparam logic [5:0] L_MDR  = 6'b000010;
  localparam logic [5:0] L_DOUT = 6'b000001;

  mc_control_p #(.TIMEOUT(4), .CNT_W(4), .MISALIGN_TRAP(1)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
    .funct7(funct7), .br_en(br_en), .addr_lo(addr_lo), .mem_resp(mem_resp),
    .load_en(load_en), .pcmux_sel(pcmux_sel), .alumux1_sel(alumux1_sel),
    .alumux2_sel(alumux2_sel), .alumux3_sel(alumux3_sel),
    .regfilemux_sel(regfilemux_sel), .marmux_sel(marmux_sel),
    .cmpmux_sel(cmpmux_sel), .cmpop(cmpop), .aluop(aluop),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_enable(mem_byte_enable), .trap(trap), .trap_cause(trap_cause),
    .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  // Runs FETCH1..DECODE and leaves the FSM in the dispatched state.
  task automatic fetch(input int unsigned waits, input logic [6:0] op,
                       input logic [2:0] f3, input logic [6:0] f7);
    chk("fetch1_load", load_en, L_MAR);
    tick();
    for (int unsigned i = 0; i < waits; i++) begin
      chk("fetch2_read", mem_read, 1);
      tick();
    end
    mem_resp = 1'b1;
    #1;
    chk("fetch2_load", load_en, L_MDR);
    tick();
    mem_resp = 1'b0;
    chk("fetch3_load", load_en, L_IR);
    opcode = op; funct3 = f3; funct7 = f7;
    tick();
    chk("decode_load", load_en, 0);
    tick();
  endtask

  initial begin
    rst_n = 1'b0; opcode = '0; funct3 = '0; funct7 = '0;
    br_en = 1'b0; addr_lo = '0; mem_resp = 1'b0;
    tick();
    tick();
    chk("rst_load_en", load_en, 0);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_instret", instret, 0);
    chk("rst_trap", trap, 0);
    rst_n = 1'b1;
    #1;

    // addi, memory answers on the second FETCH2 cycle
    fetch(1, 7'h13, 3'b000, 7'h00);
    chk("addi_load", load_en, L_PC | L_RF);
    chk("addi_aluop", aluop, 3'b000);
    tick();
    chk("addi_next", load_en, L_MAR);
    chk("addi_instret", instret, 1);

    // srai
    fetch(0, 7'h13, 3'b101, 7'h20);
    chk("srai_aluop", aluop, 3'b010);
    tick();
    // sltiu
    fetch(0, 7'h13, 3'b011, 7'h00);
    chk("sltiu_cmpop", cmpop, 3'b110);
    chk("sltiu_cmpmux", cmpmux_sel, 1);
    chk("sltiu_rfmux", regfilemux_sel, 1);
    tick();
    // sub
    fetch(0, 7'h33, 3'b000, 7'h20);
    chk("sub_aluop", aluop, 3'b011);
    chk("sub_mux3", alumux3_sel, 1);
    tick();
    // jal (funct3 deliberately not add)
    fetch(0, 7'h6F, 3'b111, 7'h00);
    chk("jal_mux1", alumux1_sel, 1);
    chk("jal_mux3", alumux3_sel, 2);
    chk("jal_rfmux", regfilemux_sel, 4);
    chk("jal_pcmux", pcmux_sel, 1);
    chk("jal_aluop", aluop, 0);
    chk("jal_load", load_en, L_PC | L_RF);
    tick();
    // bne taken
    br_en = 1'b1;
    fetch(0, 7'h63, 3'b001, 7'h00);
    chk("br_pcmux", pcmux_sel, 1);
    chk("br_mux2", alumux2_sel, 2);
    chk("br_cmpop", cmpop, 3'b001);
    chk("br_load", load_en, L_PC);
    tick();
    br_en = 1'b0;

    // sb at addr_lo=2; addr_lo changes after CALC_ADDR to prove latching
    fetch(0, 7'h23, 3'b000, 7'h00);
    addr_lo = 2'd2;
    #1;
    chk("sb_calc_load", load_en, L_MAR | L_DOUT);
    chk("sb_marmux", marmux_sel, 1);
    chk("sb_mux2", alumux2_sel, 3);
    tick();
    addr_lo = 2'd0;
    #1;
    chk("sb_st1_write", mem_write, 1);
    chk("sb_st1_be", mem_byte_enable, 4'b0100);
    mem_resp = 1'b1;
    tick();
    mem_resp = 1'b0;
    chk("sb_st2_be", mem_byte_enable, 4'b0100);
    chk("sb_st2_load", load_en, L_PC);
    tick();
    // sh at addr_lo=2
    fetch(0, 7'h23, 3'b001, 7'h00);
    addr_lo = 2'd2;
    tick();
    chk("sh_st1_be", mem_byte_enable, 4'b1100);
    mem_resp = 1'b1;
    tick();
    mem_resp = 1'b0;
    chk("sh_st2_be", mem_byte_enable, 4'b1100);
    tick();
    // aligned lw
    fetch(0, 7'h03, 3'b010, 7'h00);
    addr_lo = 2'd0;
    tick();
    chk("lw_ld1_read", mem_read, 1);
    chk("lw_ld1_load", load_en, L_MDR);
    mem_resp = 1'b1;
    tick();
    mem_resp = 1'b0;
    chk("lw_ld2_rfmux", regfilemux_sel, 3);
    chk("lw_ld2_load", load_en, L_PC | L_RF);
    tick();
    chk("instret_9", instret, 9);

    // mem_resp on the 4th FETCH2 cycle beats the timeout
    fetch(3, 7'h13, 3'b000, 7'h00);
    chk("late_resp_trap", trap, 0);
    tick();
    chk("instret_10", instret, 10);

    // reset in the middle of a load
    fetch(0, 7'h03, 3'b010, 7'h00);
    tick();
    chk("midrst_ld1_read", mem_read, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_read_gated", mem_read, 0);
    chk("midrst_load_gated", load_en, 0);
    tick();
    chk("midrst_instret", instret, 0);
    rst_n = 1'b1;
    #1;
    chk("midrst_fetch1", load_en, L_MAR);

    // 16 retirements on a 4-bit counter
    for (int i = 0; i < 16; i++) begin
      fetch(0, 7'h37, 3'b000, 7'h00);
      chk("lui_rfmux", regfilemux_sel, 2);
      tick();
      if (i == 14) chk("instret_15", instret, 15);
    end
    chk("instret_wrap", instret, 0);

    // misaligned lw
    fetch(0, 7'h03, 3'b010, 7'h00);
    addr_lo = 2'd1;
    #1;
    chk("mis_calc_load", load_en, 0);
    tick();
    chk("mis_trap", trap, 1);
    chk("mis_cause", trap_cause, 1);
    chk("mis_read", mem_read, 0);
    tick();
    chk("mis_read_hold", mem_read, 0);
    chk("mis_load_hold", load_en, 0);
    addr_lo = 2'd0;

    // csr opcode is illegal
    do_reset();
    chk("csr_pre_trap", trap, 0);
    fetch(0, 7'h73, 3'b001, 7'h00);
    chk("csr_trap", trap, 1);
    chk("csr_cause", trap_cause, 0);

    // fetch timeout after four silent FETCH2 cycles
    do_reset();
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("to_fetch2_read", mem_read, 1);
      chk("to_no_trap", trap, 0);
      tick();
    end
    chk("to_trap", trap, 1);
    chk("to_cause", trap_cause, 2);
    chk("to_read_dropped", mem_read, 0);
    mem_resp = 1'b1;
    tick();
    mem_resp = 1'b0;
    chk("to_sticky_cause", trap_cause, 2);
    chk("to_sticky_load", load_en, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mc_control_p.md
MC_CONTROL_P -- requirements
Module: mc_control_p

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64: memory-wait cycles before trap; 0 disables timeout.
REQ-002 SHALL have parameter CNT_W, default 32: width of instret.
REQ-003 SHALL have parameter MISALIGN_TRAP, default 1: 1 traps misaligned load/store, 0 issues it unchecked.
REQ-004 clk  in  1  clock; single domain, all state updates on rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 opcode  in  7  rv32i opcode of IR.
REQ-007 funct3  in  3  IR funct3.
REQ-008 funct7  in  7  IR funct7.
REQ-009 br_en  in  1  comparator result.
REQ-010 addr_lo  in  2  ALU result bits [1:0], effective address.
REQ-011 mem_resp  in  1  memory completion, one-cycle pulse.
REQ-012 load_en  out  6  {pc,ir,regfile,mar,mdr,data_out} load strobes.
REQ-013 pcmux_sel  out  1  0 = pc+4, 1 = ALU result.
REQ-014 alumux1_sel  out  1  0 = rs1, 1 = pc.
REQ-015 alumux2_sel  out  2  0 = i_imm, 1 = u_imm, 2 = b_imm, 3 = s_imm.
REQ-016 alumux3_sel  out  2  0 = mux2, 1 = rs2, 2 = j_imm.
REQ-017 regfilemux_sel  out  3  0 = alu, 1 = br_en, 2 = u_imm, 3 = mdr, 4 = pc+4.
REQ-018 marmux_sel  out  1  0 = pc, 1 = ALU.
REQ-019 cmpmux_sel  out  1  0 = rs2, 1 = i_imm.
REQ-020 cmpop  out  3  branch_funct3_t compare op.
REQ-021 aluop  out  3  alu_ops encoding.
REQ-022 mem_read  out  1  read request, held until mem_resp.
REQ-023 mem_write  out  1  write request, held until mem_resp.
REQ-024 mem_byte_enable  out  4  write byte lanes.
REQ-025 trap  out  1  sticky error flag.
REQ-026 trap_cause  out  2  0 = illegal opcode, 1 = misaligned, 2 = mem timeout.
REQ-027 instret  out  CNT_W  retired-instruction count.

Function
REQ-028 States SHALL be: FETCH1, FETCH2, FETCH3, DECODE, IMM, REG, LUI, AUIPC, BR, JAL, JALR, CALC_ADDR, LD1, LD2, ST1, ST2, TRAP.
REQ-029 Default outputs every cycle SHALL be: all strobes 0, all selects 0, cmpop = funct3, aluop = funct3, mem_byte_enable = 4'b1111.
REQ-030 Fetch SHALL run FETCH1 (load mar) -> FETCH2 (mem_read, load mdr; stay until mem_resp) -> FETCH3 (load ir) -> DECODE.
REQ-031 DECODE SHALL dispatch lui/auipc/jal/jalr/br/imm/reg to the matching state, and load/store to CALC_ADDR.
REQ-032 Any other opcode, csr included, SHALL go to TRAP with cause 0.
REQ-033 Each execute state and LD2/ST2 SHALL assert load pc for exactly one cycle, then return to FETCH1.
REQ-034 instret SHALL increment by 1 on each load-pc strobe and wrap modulo 2^CNT_W.
REQ-035 IMM: slti/sltiu SHALL use cmpop blt/bltu, cmpmux 1, regfilemux 1; srai (funct7 = 0100000) SHALL use aluop sra; all others aluop = funct3.
REQ-036 REG: slt/sltu SHALL use cmpmux 0, regfilemux 1; sub and sra are selected by funct7 = 0100000; alumux3 = 1.
REQ-037 JAL SHALL use alumux1 = 1, alumux3 = 2; JALR SHALL use alumux1 = 0.
REQ-038 JAL and JALR SHALL both use aluop add, regfilemux 4, pcmux 1, load regfile.
REQ-039 BR SHALL use pcmux = br_en, alumux1 = 1, alumux2 = 2, aluop add.
REQ-040 CALC_ADDR SHALL use aluop add and marmux 1; a store SHALL also use alumux2 = 3 and load data_out.
REQ-041 CALC_ADDR SHALL latch addr_lo and funct3 into internal registers.
REQ-042 With MISALIGN_TRAP = 1, CALC_ADDR SHALL suppress all loads and go to TRAP (cause 1) if a word access has addr_lo != 0 or a halfword access has addr_lo[0] = 1.
REQ-043 LD1 and ST1 SHALL wait for mem_resp, then go to LD2/ST2; LD2 SHALL use regfilemux 3 and load regfile.
REQ-044 ST1 and ST2 SHALL drive mem_byte_enable = 0001 << addr_lo for sb, 0011 << addr_lo for sh, 1111 for sw, using the latched values.
REQ-045 A wait counter SHALL clear on entry to FETCH2, LD1 or ST1 and increment each cycle without mem_resp.
REQ-046 If TIMEOUT > 0 and the wait counter reaches TIMEOUT - 1 with no mem_resp, the next state SHALL be TRAP with cause 2 and requests dropped.
REQ-047 mem_resp arriving in the same cycle as the timeout limit SHALL win, and the access completes normally.
REQ-048 TRAP SHALL drive all strobes and requests 0 and hold until reset; trap = 1, and trap_cause is fixed at first entry.

Reset
REQ-049 While rst_n = 0 at a rising edge, the next state SHALL be FETCH1, instret, trap, trap_cause, wait counter and latches SHALL be 0, and all strobes 0; this includes reset mid-access.

Verification
REQ-050 Reset, then addi with mem_resp on the 2nd FETCH2 cycle -> FETCH1, FETCH2 x2, FETCH3, DECODE, IMM, FETCH1; instret = 1.
REQ-051 sb with addr_lo = 2 -> mem_byte_enable = 0100 in ST1/ST2; sh with addr_lo = 2 -> 1100.
REQ-052 lw with addr_lo = 1, MISALIGN_TRAP = 1 -> TRAP, trap_cause = 1, mem_read never asserted.
REQ-053 TIMEOUT = 4, no mem_resp in FETCH2 -> TRAP after 4 FETCH2 cycles, cause 2; with mem_resp on the 4th cycle -> FETCH3 instead.
REQ-054 opcode 0x73 (csr) -> TRAP cause 0; rst_n low in LD1 -> FETCH1 with instret = 0.
REQ-055 CNT_W = 4, 16 retirements -> instret wraps to 0.
